// File: rtl/scoreboard_pkg.sv
// Shared definitions for the score display: conversion FSM states,
// seven-segment patterns ({g,f,e,d,c,b,a}, active-high) and the score limit.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam int MAX_SCORE = 99;

  localparam logic [3:0] BCD_DASH = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-seven-segment decoder; 4'hF shows a dash,
// other non-decimal codes are blank.
module seg7_decoder
  import scoreboard_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:     seg_o = SEG_0;
      4'd1:     seg_o = SEG_1;
      4'd2:     seg_o = SEG_2;
      4'd3:     seg_o = SEG_3;
      4'd4:     seg_o = SEG_4;
      4'd5:     seg_o = SEG_5;
      4'd6:     seg_o = SEG_6;
      4'd7:     seg_o = SEG_7;
      4'd8:     seg_o = SEG_8;
      4'd9:     seg_o = SEG_9;
      BCD_DASH: seg_o = SEG_DASH;
      default:  seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Two-digit multiplexed score display: a double-dabble FSM converts the
// binary score to BCD whenever it changes; a free-running refresh scans digits.
module score_display
  import scoreboard_pkg::*;
#(
  parameter int BW          = 7,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [BW-1:0] cnt_val_i,
  output logic [6:0]    seg_o,
  output logic [1:0]    dig_sel_o,
  output logic [3:0]    bcd_tens_o,
  output logic [3:0]    bcd_ones_o,
  output logic          busy_o,
  output logic          ovf_o
);

  localparam int ND = 2;
  localparam int SW = 4 * ND;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  localparam int RW = $clog2(REFRESH_DIV);

  state_e          state_q, state_d;
  logic [BW-1:0]   last_val_q, last_val_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   shcnt_q, shcnt_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   refresh_q, refresh_d;
  logic [1:0]      dig_sel_q, dig_sel_d;
  logic [SW-1:0]   bcd_adj;
  logic            over;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  for (genvar gi = 0; gi < ND; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
  end

  assign over = (32'(last_val_q) > MAX_SCORE);

  always_comb begin
    state_d    = state_q;
    last_val_d = last_val_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    shcnt_d    = shcnt_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_val_i != last_val_q) begin
          state_d    = ST_SHIFT;
          last_val_d = cnt_val_i;
          bin_d      = cnt_val_i;
          bcd_d      = '0;
          shcnt_d    = '0;
        end
      end
      ST_SHIFT: begin
        // Two digits suffice for in-range scores; the bit leaving the scratch
        // only matters for overflow values, whose digits are overridden anyway.
        bcd_d   = {bcd_adj[SW-2:0], bin_q[BW-1]};
        bin_d   = {bin_q[BW-2:0], bcd_adj[SW-1]};
        shcnt_d = CW'(shcnt_q + 1'b1);
        if (shcnt_q == CW'(BW - 1)) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        ovf_d   = over;
        tens_d  = over ? BCD_DASH : bcd_q[7:4];
        ones_d  = over ? BCD_DASH : bcd_q[3:0];
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      last_val_q <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      shcnt_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_val_q <= last_val_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      shcnt_q    <= shcnt_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    refresh_d = RW'(refresh_q + 1'b1);
    dig_sel_d = dig_sel_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      dig_sel_d = {dig_sel_q[0], dig_sel_q[1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refresh_q <= '0;
      dig_sel_q <= 2'b01;
    end else begin
      refresh_q <= refresh_d;
      dig_sel_q <= dig_sel_d;
    end
  end

  logic       tens_slot;
  logic [3:0] dec_code;
  logic [6:0] dec_seg;
  logic       blank;

  assign tens_slot = dig_sel_q[1];
  assign dec_code  = tens_slot ? tens_q : ones_q;
  assign blank     = (LZ_BLANK != 0) && tens_slot && !ovf_q && (tens_q == 4'd0);

  seg7_decoder u_dec (
    .code_i (dec_code),
    .seg_o  (dec_seg)
  );

  assign seg_o      = blank ? SEG_BLANK : dec_seg;
  assign dig_sel_o  = dig_sel_q;
  assign bcd_tens_o = tens_q;
  assign bcd_ones_o = ones_q;
  assign ovf_o      = ovf_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: stimulus pushes expected conversion
// results; a monitor pops and checks them each time busy_o falls.
module tb_score_display;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [6:0] cnt_val_i;
  logic [6:0] seg_o;
  logic [1:0] dig_sel_o;
  logic [3:0] bcd_tens_o;
  logic [3:0] bcd_ones_o;
  logic       busy_o;
  logic       ovf_o;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  score_display #(.BW(7), .REFRESH_DIV(4), .LZ_BLANK(1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cnt_val_i  (cnt_val_i),
    .seg_o      (seg_o),
    .dig_sel_o  (dig_sel_o),
    .bcd_tens_o (bcd_tens_o),
    .bcd_ones_o (bcd_ones_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [3:0] t, input logic [3:0] o, input logic v);
    exp_t e;
    e.tens = t; e.ones = o; e.ovf = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Wait (bounded) for the requested digit slot, then compare its pattern.
  task automatic check_slot(input logic [1:0] sel, input logic [6:0] exp, input string name);
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk_i);
      if (dig_sel_o == sel) found = 1;
    end
    if (found) chk(name, seg_o, exp);
    else chk({name, "_slot_timeout"}, dig_sel_o, sel);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !busy_o) done = 1;
    end
    if (!done) chk({name, "_timeout"}, sb.size(), 0);
  endtask

  // Monitor: a falling busy_o marks a finished conversion.
  initial begin
    bit prev_busy = 0;
    int busy_len  = 0;
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        prev_busy = 0;
        busy_len  = 0;
      end else begin
        if (busy_o) busy_len++;
        else if (prev_busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_conv", 1, 0);
          end else begin
            e = sb.pop_front();
            $display("conv: tens=%0h ones=%0h ovf=%0b busy_cycles=%0d",
                     bcd_tens_o, bcd_ones_o, ovf_o, busy_len);
            chk("conv_tens", bcd_tens_o, e.tens);
            chk("conv_ones", bcd_ones_o, e.ones);
            chk("conv_ovf", ovf_o, e.ovf);
            chk("conv_busy_len", busy_len, 8);
          end
          busy_len = 0;
        end
        prev_busy = busy_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_seen;
    logic [1:0] prev_sel;
    int run;
    bit first_toggle;

    rst_i     = 1'b0;
    cnt_val_i = 7'd0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_dig_sel", dig_sel_o, 2'b01);
    chk("rst_busy", busy_o, 0);
    chk("rst_tens", bcd_tens_o, 0);
    chk("rst_ones", bcd_ones_o, 0);
    chk("rst_ovf", ovf_o, 0);
    rst_i = 1'b1;

    // Value 0 equals the reset last_val: no conversion.
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_o) busy_seen = 1;
    end
    chk("zero_no_busy", busy_seen, 0);
    check_slot(2'b01, 7'b0111111, "zero_ones_seg");
    check_slot(2'b10, 7'b0000000, "zero_tens_blank");

    // 57: latency check around the ninth edge.
    tick();
    cnt_val_i = 7'd57;
    push(4'd5, 4'd7, 1'b0);
    repeat (8) @(posedge clk_i);
    #1;
    chk("lat8_busy", busy_o, 1);
    chk("lat8_tens_old", bcd_tens_o, 0);
    @(posedge clk_i);
    #1;
    chk("lat9_busy", busy_o, 0);
    chk("lat9_tens", bcd_tens_o, 5);
    chk("lat9_ones", bcd_ones_o, 7);
    wait_done(40, "c57");
    check_slot(2'b10, 7'b1101101, "s57_tens");
    check_slot(2'b01, 7'b0000111, "s57_ones");

    tick();
    cnt_val_i = 7'd99;
    push(4'd9, 4'd9, 1'b0);
    wait_done(40, "c99");
    check_slot(2'b10, 7'b1101111, "s99_tens");
    check_slot(2'b01, 7'b1101111, "s99_ones");

    tick();
    cnt_val_i = 7'd100;
    push(4'hF, 4'hF, 1'b1);
    wait_done(40, "c100");
    chk("ovf_level", ovf_o, 1);
    check_slot(2'b10, 7'b1000000, "s100_tens");
    check_slot(2'b01, 7'b1000000, "s100_ones");

    // 12 then 13 one cycle after the first conversion starts.
    tick();
    cnt_val_i = 7'd12;
    push(4'd1, 4'd2, 1'b0);
    push(4'd1, 4'd3, 1'b0);
    tick();
    cnt_val_i = 7'd13;
    wait_done(60, "c12_13");
    chk("final13_ones", bcd_ones_o, 3);
    chk("final13_ovf", ovf_o, 0);

    // Reset three cycles into a conversion of 42.
    tick();
    cnt_val_i = 7'd42;
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_tens", bcd_tens_o, 0);
    chk("mid_rst_ones", bcd_ones_o, 0);
    chk("mid_rst_dig_sel", dig_sel_o, 2'b01);
    repeat (2) tick();
    push(4'd4, 4'd2, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_start", busy_o, 1);
    wait_done(40, "c42");
    chk("c42_tens", bcd_tens_o, 4);
    chk("c42_ones", bcd_ones_o, 2);

    // Refresh cadence over 40 cycles.
    @(negedge clk_i);
    prev_sel     = dig_sel_o;
    run          = 1;
    first_toggle = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      chk("onehot", $countones(dig_sel_o), 1);
      if (dig_sel_o != prev_sel) begin
        if (!first_toggle) chk("toggle_period", run, 4);
        first_toggle = 0;
        run = 1;
      end else begin
        run++;
      end
      prev_sel = dig_sel_o;
    end

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter BW, default 7, width of the binary score input.
REQ-002 Parameter REFRESH_DIV, default 50000, clk_i cycles per digit slot; minimum 2.
REQ-003 Parameter LZ_BLANK, default 1, 1 = blank the tens digit when it is 0.
REQ-004 The design SHALL use one clock and one reset: clk_i (single clock, rising edge) and rst_i (asynchronous, active-low).
REQ-005 clk_i  input  1  system clock, rising edge.
REQ-006 rst_i  input  1  asynchronous active-low reset.
REQ-007 cnt_val_i  input  BW  binary score from the up/down counter, legal range 0-99.
REQ-008 seg_o  output  7  segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
REQ-009 dig_sel_o  output  2  one-hot digit enable, bit0 = ones, bit1 = tens.
REQ-010 bcd_tens_o  output  4  latched BCD tens digit.
REQ-011 bcd_ones_o  output  4  latched BCD ones digit.
REQ-012 busy_o  output  1  high while a conversion is in progress.
REQ-013 ovf_o  output  1  high while the displayed value is out of range (>99).

Function
REQ-014 States IDLE, SHIFT, LOAD; IDLE -> SHIFT when cnt_val_i != last_val; SHIFT -> LOAD after exactly BW shift cycles; LOAD -> IDLE unconditionally.
REQ-015 On IDLE->SHIFT, cnt_val_i SHALL be captured into last_val and the shift register; the BCD scratch SHALL be cleared.
REQ-016 Each SHIFT cycle SHALL add 3 to every BCD nibble >= 5, then shift the {BCD, binary} register left by one (double-dabble).
REQ-017 LOAD SHALL copy scratch to bcd_tens_o/bcd_ones_o and ovf_o; latency from input change to updated outputs = BW+2 cycles.
REQ-018 Changes of cnt_val_i during SHIFT or LOAD SHALL be ignored and picked up by the IDLE compare afterwards; no conversion is aborted.
REQ-019 busy_o SHALL be high in SHIFT and LOAD, low in IDLE.
REQ-020 Captured value > 99: ovf_o = 1, bcd_tens_o = bcd_ones_o = 4'hF, both digits show dash (g only).
REQ-021 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap dig_sel_o toggles 01 <-> 10.
REQ-022 seg_o SHALL be the decoded digit selected by dig_sel_o; digits 0-9 standard patterns, 4'hF = dash.
REQ-023 With LZ_BLANK = 1, ovf_o = 0 and bcd_tens_o = 0, seg_o SHALL be 0 while the tens slot is active.
REQ-024 Display refresh SHALL run independently of the conversion FSM; register update in LOAD takes effect on the next cycle in whichever slot is active.

Reset
REQ-025 rst_i low SHALL immediately force: state IDLE, last_val 0, bcd_tens_o 0, bcd_ones_o 0, busy_o 0, ovf_o 0, refresh counter 0, dig_sel_o 2'b01.
REQ-026 Reset asserted mid-conversion SHALL discard the partial result; after release, a nonzero cnt_val_i starts a fresh conversion on the first clock edge.
REQ-027 Reset deassertion SHALL take effect on the next rising clk_i edge; no output glitches other than the reset values.

Structure
REQ-028 Shared package scoreboard_pkg SHALL hold state encodings, segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK) and the limit constant MAX_SCORE = 99.
REQ-029 One combinational sub-module seg7_decoder (4-bit code in, 7-bit pattern out) SHALL be instantiated once.

Verification (BW=7, REFRESH_DIV=4, LZ_BLANK=1)
REQ-030 Reset, cnt_val_i=0 -> busy_o stays 0, dig_sel_o 01, seg_o 7'b0111111; tens slot seg_o 0.
REQ-031 cnt_val_i 0->57 -> busy_o high 8 cycles, 9 cycles after change tens=5, ones=7; seg_o 7'b1101101 (tens), 7'b0000111 (ones).
REQ-032 cnt_val_i 99 then 100 -> 99 shows 9/9; 100 gives ovf_o=1, both slots seg_o 7'b1000000.
REQ-033 cnt_val_i 12 then 13 one cycle after conversion starts -> 12 displayed first, then 13 after a second conversion; no value lost.
REQ-034 rst_i low 3 cycles into a conversion of 42 -> all outputs at reset values; after release 42 converted fully, tens=4, ones=2.
REQ-035 Refresh: dig_sel_o toggles exactly every 4 cycles for 40 cycles, always one-hot.
